// File: rtl/player_input_ctrl.sv
// Per-player button conditioning: 2-FF sync, debounce, and a frame-aligned op vector.
// Define PLAYER_INPUT_JUMP_BUFFER_EN to hold a jump request through the cooldown window.
module player_input_ctrl #(
    parameter int DB_CYCLES     = 1000000,
    parameter int DB_CNT_W      = 20,
    parameter int JUMP_COOLDOWN = 4,
    parameter int SMASH_HOLD    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_pitch,
    input  logic       en,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_press,
    output logic       op_move_left,
    output logic       op_move_right,
    output logic       op_jump,
    output logic       op_smash,
    output logic       op_valid
);

    localparam int BTN_RIGHT = 0;
    localparam int BTN_JUMP  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_SMASH = 3;

    localparam int CD_W = (JUMP_COOLDOWN > 0) ? $clog2(JUMP_COOLDOWN + 1) : 1;
    localparam int SH_W = (SMASH_HOLD > 1) ? $clog2(SMASH_HOLD + 1) : 1;

    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);
    localparam logic [DB_CNT_W-1:0] DB_ONE  = DB_CNT_W'(1);
    localparam logic [CD_W-1:0]     CD_LOAD = CD_W'(JUMP_COOLDOWN);
    localparam logic [CD_W-1:0]     CD_ONE  = CD_W'(1);
    localparam logic [SH_W-1:0]     SH_LOAD = SH_W'(SMASH_HOLD - 1);
    localparam logic [SH_W-1:0]     SH_ONE  = SH_W'(1);

    logic [3:0]          sync_meta;
    logic [3:0]          sync_q;
    logic [3:0]          stable;
    logic [3:0]          stable_d;
    logic [DB_CNT_W-1:0] db_cnt [4];

    logic            left_seen;
    logic            right_seen;
    logic            jump_req;
    logic            smash_req;
    logic [CD_W-1:0] cooldown;
    logic [SH_W-1:0] smash_cnt;
    logic            jump_fire;
    logic            jump_keep;

    assign jump_fire = jump_req && (cooldown == '0);

`ifdef PLAYER_INPUT_JUMP_BUFFER_EN
    assign jump_keep = jump_req && (cooldown != '0);
`else
    assign jump_keep = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
            stable    <= '0;
            stable_d  <= '0;
            btn_press <= '0;
            // NOTE: the debounce counters are a small register array, not RAM, so they take the reset.
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync_q    <= sync_meta;
            stable_d  <= stable;
            btn_press <= stable & ~stable_d;
            for (int i = 0; i < 4; i++) begin
                if (sync_q[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_move_left  <= 1'b0;
            op_move_right <= 1'b0;
            op_jump       <= 1'b0;
            op_smash      <= 1'b0;
            op_valid      <= 1'b0;
            left_seen     <= 1'b0;
            right_seen    <= 1'b0;
            jump_req      <= 1'b0;
            smash_req     <= 1'b0;
            cooldown      <= '0;
            smash_cnt     <= '0;
        end else begin
            op_valid <= 1'b0;
            if (frame_pitch && en) begin
                op_valid      <= 1'b1;
                op_move_left  <= left_seen & ~right_seen;
                op_move_right <= right_seen & ~left_seen;
                op_jump       <= jump_fire;
                if (jump_fire) begin
                    cooldown <= CD_LOAD;
                end else if (cooldown != '0) begin
                    cooldown <= cooldown - CD_ONE;
                end
                if (smash_req) begin
                    smash_cnt <= SH_LOAD;
                    op_smash  <= 1'b1;
                end else begin
                    op_smash <= (smash_cnt != '0);
                    if (smash_cnt != '0) smash_cnt <= smash_cnt - SH_ONE;
                end
                // An event on the tick cycle itself belongs to the next frame.
                left_seen  <= stable[BTN_LEFT];
                right_seen <= stable[BTN_RIGHT];
                jump_req   <= btn_press[BTN_JUMP] | jump_keep;
                smash_req  <= btn_press[BTN_SMASH];
            end else if (frame_pitch) begin
                op_move_left  <= 1'b0;
                op_move_right <= 1'b0;
                op_jump       <= 1'b0;
                op_smash      <= 1'b0;
                left_seen     <= 1'b0;
                right_seen    <= 1'b0;
                jump_req      <= 1'b0;
                smash_req     <= 1'b0;
                cooldown      <= '0;
                smash_cnt     <= '0;
            end else begin
                left_seen  <= left_seen  | stable[BTN_LEFT];
                right_seen <= right_seen | stable[BTN_RIGHT];
                jump_req   <= jump_req   | btn_press[BTN_JUMP];
                smash_req  <= smash_req  | btn_press[BTN_SMASH];
            end
        end
    end

endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl: directed scenarios with literal expectations plus
// randomized buttons/enable checked every cycle against a frame-level reference model.
module tb_player_input_ctrl;

    localparam int DB    = 4;
    localparam int DBW   = 3;
    localparam int JC    = 2;
    localparam int SH    = 3;
    localparam int FRAME = 20;
    localparam int NONE  = -100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_pitch = 1'b0;
    logic       en = 1'b0;
    logic [3:0] btn_raw = '0;
    logic [3:0] btn_press;
    logic       op_move_left, op_move_right, op_jump, op_smash, op_valid;

    int errors = 0;
    int checks = 0;

    player_input_ctrl #(
        .DB_CYCLES    (DB),
        .DB_CNT_W     (DBW),
        .JUMP_COOLDOWN(JC),
        .SMASH_HOLD   (SH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_pitch  (frame_pitch),
        .en           (en),
        .btn_raw      (btn_raw),
        .btn_press    (btn_press),
        .op_move_left (op_move_left),
        .op_move_right(op_move_right),
        .op_jump      (op_jump),
        .op_smash     (op_smash),
        .op_valid     (op_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Free-running frame tick, one cycle in every FRAME.
    int fcnt = 0;
    initial forever begin
        @(negedge clk);
        fcnt = (fcnt == FRAME - 1) ? 0 : fcnt + 1;
        frame_pitch = (fcnt == FRAME - 1);
    end

    // ---------------- reference model ----------------
    logic [3:0] rq0, rq1;
    logic [3:0] sh_hist [$];
    int         edge_n;
    int         flip_at [4];
    logic [3:0] m_stable, m_stable_d, m_press;
    logic       acc_l, acc_r, acc_j, acc_s;
    int         n_tick, last_jump, last_smash;
    logic       m_l, m_r, m_j, m_s, m_v;

    task automatic model_reset();
        rq0 = '0; rq1 = '0;
        sh_hist.delete();
        edge_n = 0;
        for (int i = 0; i < 4; i++) flip_at[i] = 0;
        m_stable = '0; m_stable_d = '0; m_press = '0;
        acc_l = 0; acc_r = 0; acc_j = 0; acc_s = 0;
        n_tick = 0; last_jump = NONE; last_smash = NONE;
        m_l = 0; m_r = 0; m_j = 0; m_s = 0; m_v = 0;
    endtask

    task automatic model_step();
        logic [3:0] s, nstable, npress;
        logic       c_l, c_r, c_j, c_s, cd_ok, keep, all_diff;
        edge_n++;
        s   = rq1;
        rq1 = rq0;
        rq0 = btn_raw;
        sh_hist.push_front(s);
        if (sh_hist.size() > DB) void'(sh_hist.pop_back());
        // A level is accepted once DB consecutive synced samples disagree with it.
        nstable = m_stable;
        for (int i = 0; i < 4; i++) begin
            all_diff = (sh_hist.size() == DB);
            foreach (sh_hist[j]) if (sh_hist[j][i] == m_stable[i]) all_diff = 0;
            if (all_diff && (edge_n - flip_at[i] >= DB)) begin
                nstable[i] = ~m_stable[i];
                flip_at[i] = edge_n;
            end
        end
        npress = m_stable & ~m_stable_d;
        c_l = m_stable[2]; c_r = m_stable[0]; c_j = m_press[1]; c_s = m_press[3];
        m_v = 0;
        if (frame_pitch && en) begin
            m_v   = 1;
            m_l   = acc_l & ~acc_r;
            m_r   = acc_r & ~acc_l;
            cd_ok = (n_tick - last_jump) > JC;
            m_j   = acc_j && cd_ok;
            if (m_j) last_jump = n_tick;
`ifdef PLAYER_INPUT_JUMP_BUFFER_EN
            keep = acc_j && !cd_ok;
`else
            keep = 0;
`endif
            if (acc_s) last_smash = n_tick;
            m_s = (n_tick - last_smash) < SH;
            n_tick++;
            acc_l = c_l; acc_r = c_r; acc_j = c_j | keep; acc_s = c_s;
        end else if (frame_pitch) begin
            m_l = 0; m_r = 0; m_j = 0; m_s = 0;
            acc_l = 0; acc_r = 0; acc_j = 0; acc_s = 0;
            last_jump = NONE; last_smash = NONE;
        end else begin
            acc_l |= c_l; acc_r |= c_r; acc_j |= c_j; acc_s |= c_s;
        end
        m_stable_d = m_stable;
        m_stable   = nstable;
        m_press    = npress;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        if (reset_n)
            check("outputs", {btn_press, op_move_left, op_move_right, op_jump, op_smash, op_valid},
                  {m_press, m_l, m_r, m_j, m_s, m_v});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
    endtask

    task automatic next_valid(input string name, output logic [3:0] ops);
        ops = 'x;
        for (int i = 0; i < 60; i++) begin
            step();
            if (op_valid) begin
                ops = {op_move_left, op_move_right, op_jump, op_smash};
                return;
            end
        end
        check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_press(input int idx, input string name, output int at);
        at = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (btn_press[idx]) begin
                at = k;
                return;
            end
        end
        check({name, "_timeout"}, 0, 1);
    endtask

    task automatic press_train(input int idx, input int n);
        repeat (n) begin
            btn_raw[idx] = 1'b1;
            step(8);
            btn_raw[idx] = 1'b0;
            step(12);
        end
    endtask

    task automatic collect(input int idx, input int n, input string name, output logic [7:0] pat);
        logic [3:0] ops;
        int at;
        pat = '0;
        wait_press(idx, name, at);
        step();
        for (int i = 0; i < n; i++) begin
            next_valid(name, ops);
            pat = {pat[6:0], (idx == 1) ? ops[1] : ops[0]};
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] ops;
        logic [7:0] pat;
        int first, cnt, at, hold [4];
        bit seen_press, seen_left, found;

        step(3);
        check("reset_state", {btn_press, op_move_left, op_move_right, op_jump, op_smash, op_valid}, 0);
        reset_n = 1'b1;
        en = 1'b1;
        step(2);

        // Bounce on left never qualifies.
        seen_press = 0; seen_left = 0;
        for (int i = 0; i < 40; i++) begin
            if (i < 30) btn_raw[2] = ((i / 2) % 2 == 0);
            else        btn_raw[2] = 1'b0;
            step();
            if (btn_press != 0) seen_press = 1;
            if (op_move_left)   seen_left = 1;
        end
        check("bounce_press", 32'(seen_press), 0);
        check("bounce_left", 32'(seen_left), 0);

        // Clean right press: pulse seven cycles after the raw edge.
        btn_raw[0] = 1'b1;
        first = -1; cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (btn_press[0]) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        check("press_cycle", 32'(first), 7);
        check("press_count", 32'(cnt), 1);
        next_valid("clean_right", ops);
        check("clean_right_lr", 32'(ops[3:2]), 32'b01);
        btn_raw = '0;
        step(10);

        // Left and right together cancel.
        btn_raw = 4'b0101;
        step(8);
        next_valid("lr_both", ops);
        check("lr_both", 32'(ops[3:2]), 0);
        btn_raw = '0;
        step(45);

        // Jump pressed every frame.
        do_reset();
        step(2);
        fork
            press_train(1, 7);
            collect(1, 6, "jump_every", pat);
        join
        check("jump_every_frame", 32'(pat[5:0]), 32'b100100);
        step(10);

        // One extra press during cooldown.
        do_reset();
        step(2);
        fork
            press_train(1, 2);
            collect(1, 5, "jump_buf", pat);
        join
`ifdef PLAYER_INPUT_JUMP_BUFFER_EN
        check("jump_buffered", 32'(pat[4:0]), 32'b10010);
`else
        check("jump_dropped", 32'(pat[4:0]), 32'b10000);
`endif
        step(10);

        // Single smash press holds three frames.
        fork
            press_train(3, 1);
            collect(3, 5, "smash", pat);
        join
        check("smash_hold", 32'(pat[4:0]), 32'b11100);
        step(20);

        // Disabled tick: no op_valid, ops cleared, press still pulses.
        en = 1'b0;
        btn_raw[1] = 1'b1;
        wait_press(1, "en0_press", at);
        check("en0_press", 32'(at > 0), 1);
        btn_raw[1] = 1'b0;
        found = 0;
        for (int i = 0; i < 25 && !found; i++) begin
            step();
            if (frame_pitch) found = 1;
        end
        check("en0_tick_seen", 32'(found), 1);
        step();
        check("en0_tick", {op_valid, op_move_left, op_move_right, op_jump, op_smash}, 0);
        en = 1'b1;
        next_valid("en0_then", ops);
        check("en0_then_jump", 32'(ops[1]), 0);
        step(5);

        // Reset with a jump request pending.
        next_valid("rst_sync", ops);
        step();
        btn_raw[1] = 1'b1;
        wait_press(1, "rst_press", at);
        btn_raw[1] = 1'b0;
        step(2);
        #2 reset_n = 1'b0;
        #1 check("reset_async", {btn_press, op_move_left, op_move_right, op_jump, op_smash, op_valid}, 0);
        step(2);
        reset_n = 1'b1;
        pat = '0;
        for (int i = 0; i < 3; i++) begin
            next_valid("rst_nojump", ops);
            pat = {pat[6:0], ops[1]};
        end
        check("reset_no_jump", 32'(pat[2:0]), 0);

        // Randomized buttons and enable, checked every cycle by the model.
        for (int i = 0; i < 4; i++) hold[i] = 1;
        repeat (3000) begin
            step();
            for (int i = 0; i < 4; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 30))
                                                          : int'($urandom_range(1, 4));
                end
            end
            if ($urandom_range(0, 199) == 0) en = ~en;
        end

        step(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
